// File: rtl/pc_fetch_stage_if.sv
// Fetch-stage bus: adder operand/result, instruction fetch address,
// IF/ID register outputs and the downstream stall/redirect controls.
interface pc_fetch_stage_if #(
  parameter int DATA_W = 64
);
  logic              stall;
  logic              redirect;
  logic [DATA_W-1:0] redirect_pc;
  logic [DATA_W-1:0] add_a;
  logic [DATA_W-1:0] add_b;
  logic [DATA_W-1:0] add_sum;
  logic [DATA_W-1:0] imem_addr;
  logic [DATA_W-1:0] if_pc;
  logic              if_valid;
  logic              fault;

  modport master (
    input  stall, redirect, redirect_pc, add_sum,
    output add_a, add_b, imem_addr, if_pc, if_valid, fault
  );

  modport slave (
    output stall, redirect, redirect_pc, add_sum,
    input  add_a, add_b, imem_addr, if_pc, if_valid, fault
  );
endinterface

// File: rtl/pc_fetch_stage.sv
// IF-stage program counter and IF/ID register. The next sequential PC
// comes back from the shared external adder; redirects and stalls override it.
module pc_fetch_stage #(
  parameter int              DATA_W   = 64,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  pc_fetch_stage_if.master bus
);
  typedef enum logic [1:0] {RUN, HOLD, FAULT} state_t;

  state_t            state;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] if_pc_q;
  logic              if_valid_q;
  logic              fault_q;
  logic              misaligned;

  assign misaligned = bus.redirect_pc[1:0] != 2'b00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      pc         <= RESET_PC;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      case (state)
        RUN, HOLD: begin
          if (bus.redirect) begin
            if_valid_q <= 1'b0;
            if (!misaligned) begin
              pc      <= bus.redirect_pc;
              if_pc_q <= pc;
              state   <= RUN;
            end else begin
              // Bad target: freeze the front end until reset.
              fault_q <= 1'b1;
              state   <= FAULT;
            end
          end else if (bus.stall) begin
            state <= HOLD;
          end else begin
            pc         <= bus.add_sum;
            if_pc_q    <= pc;
            if_valid_q <= 1'b1;
            state      <= RUN;
          end
        end
        FAULT: begin
          if_valid_q <= 1'b0;
          fault_q    <= 1'b1;
        end
        default: state <= FAULT;
      endcase
    end
  end

  assign bus.add_a     = pc;
  assign bus.add_b     = DATA_W'(PC_STEP);
  assign bus.imem_addr = pc;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.fault     = fault_q;
endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: stimulus pushes the state expected after
// each clock edge, a monitor pops and compares on the following falling edge.
module tb_pc_fetch_stage;
  localparam int DATA_W = 64;

  typedef struct {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] if_pc;
    logic              valid;
    logic              fault;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  pc_fetch_stage_if #(.DATA_W(DATA_W)) bus ();

  pc_fetch_stage #(.DATA_W(DATA_W), .RESET_PC('0), .PC_STEP(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // External ripple adder model.
  assign bus.add_sum = bus.add_a + bus.add_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_imem"},  bus.imem_addr, 64'h0);
    check({tag, "_ifpc"},  bus.if_pc, 64'h0);
    check({tag, "_valid"}, {63'h0, bus.if_valid}, 64'h0);
    check({tag, "_fault"}, {63'h0, bus.fault}, 64'h0);
  endtask

  always @(negedge clk) begin
    if (reset_n && sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check("imem_addr", bus.imem_addr, e.pc);
      check("add_a", bus.add_a, e.pc);
      check("add_b", bus.add_b, 64'd4);
      check("if_pc", bus.if_pc, e.if_pc);
      check("if_valid", {63'h0, bus.if_valid}, {63'h0, e.valid});
      check("fault", {63'h0, bus.fault}, {63'h0, e.fault});
    end
  end

  // Called at negedge+1: drive inputs, queue the post-edge expectation, wait a cycle.
  task automatic step(input logic st, input logic rd, input logic [DATA_W-1:0] rpc,
                      input logic [DATA_W-1:0] epc, input logic [DATA_W-1:0] eifpc,
                      input logic ev, input logic ef);
    exp_t e;
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    e.pc = epc; e.if_pc = eifpc; e.valid = ev; e.fault = ef;
    sb.push_back(e);
    @(negedge clk); #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    #2 check_reset("rst");
    @(negedge clk); #1;
    reset_n = 1'b1;
    // T1 sequential fetch
    step(0, 0, 0, 64'h04, 64'h00, 1, 0);
    step(0, 0, 0, 64'h08, 64'h04, 1, 0);
    step(0, 0, 0, 64'h0C, 64'h08, 1, 0);
    step(0, 0, 0, 64'h10, 64'h0C, 1, 0);
    // T2 three-cycle stall at 0x10
    step(1, 0, 0, 64'h10, 64'h0C, 1, 0);
    step(1, 0, 0, 64'h10, 64'h0C, 1, 0);
    step(1, 0, 0, 64'h10, 64'h0C, 1, 0);
    step(0, 0, 0, 64'h14, 64'h10, 1, 0);
    step(0, 0, 0, 64'h18, 64'h14, 1, 0);
    step(0, 0, 0, 64'h1C, 64'h18, 1, 0);
    step(0, 0, 0, 64'h20, 64'h1C, 1, 0);
    // T3 redirect to 0x100
    step(0, 1, 64'h100, 64'h100, 64'h20, 0, 0);
    step(0, 0, 0,       64'h104, 64'h100, 1, 0);
    // T4 redirect beats stall
    step(1, 1, 64'h200, 64'h200, 64'h104, 0, 0);
    step(0, 0, 0,       64'h204, 64'h200, 1, 0);
    // T6 wrap-around at the top of the address space
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 64'h204, 0, 0);
    step(0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF8, 1, 0);
    step(0, 0, 0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0);
    step(0, 0, 0, 64'h4, 64'h0, 1, 0);
    // T5 misaligned redirect: sticky fault, everything frozen
    step(0, 1, 64'h102, 64'h4, 64'h0, 0, 1);
    step(0, 1, 64'h300, 64'h4, 64'h0, 0, 1);
    step(1, 0, 0,       64'h4, 64'h0, 0, 1);
    step(0, 0, 0,       64'h4, 64'h0, 0, 1);
    // Asynchronous reset mid-fault with requests pending
    bus.stall = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 64'h400;
    reset_n = 1'b0;
    #1 check_reset("async_rst");
    @(negedge clk); #1;
    check_reset("held_rst");
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    reset_n = 1'b1;
    step(0, 0, 0, 64'h4, 64'h0, 1, 0);
    step(0, 0, 0, 64'h8, 64'h4, 1, 0);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
